// File: rtl/lieat_exu_share_arb_pkg.sv
// Shared EXU-share definitions: requester indices, widths, slot type.
// Also hosts the round-robin pointer advance helper.
package lieat_exu_share_arb_pkg;

  localparam int EXU_XLEN    = 32;
  localparam int EXU_NREQ    = 3;
  localparam int EXU_REQ_ALU = 0;
  localparam int EXU_REQ_BJP = 1;
  localparam int EXU_REQ_CSR = 2;

  function automatic logic [1:0] rr_next(
    input logic [2:0] gnt
  );
    logic [1:0] nxt;
    nxt = 2'd0;
    unique case (1'b1)
      gnt[0]:  nxt = 2'd1;
      gnt[1]:  nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/lieat_exu_share_arb_rr_arb3.sv
// 3-way round-robin picker: first set req bit at or after ptr.
// Pointer value 3 behaves as 0.
module lieat_rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  logic [1:0] p;
  logic [2:0] rot;
  logic [2:0] pick;

  always_comb begin
    p    = (ptr == 2'd3) ? 2'd0 : ptr;
    rot  = req;
    gnt  = 3'b000;
    // rotate so the pointed-to requester sits at bit 0
    unique case (p)
      2'd1:    rot = {req[0], req[2:1]};
      2'd2:    rot = {req[1:0], req[2]};
      default: rot = req;
    endcase
    pick = rot[0] ? 3'b001 :
           rot[1] ? 3'b010 :
           rot[2] ? 3'b100 : 3'b000;
    unique case (p)
      2'd1:    gnt = {pick[1:0], pick[2]};
      2'd2:    gnt = {pick[0], pick[2:1]};
      default: gnt = pick;
    endcase
  end

endmodule

// File: rtl/lieat_exu_share_arb.sv
// Round-robin scheduler for the shared EXU datapath.
// One grant per cycle; results parked in per-requester response slots.
module lieat_exu_share_arb
  import lieat_exu_share_arb_pkg::*;
#(
  parameter int XLEN = EXU_XLEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [EXU_NREQ-1:0]        req_valid,
  output logic [EXU_NREQ-1:0]        req_ready,
  output logic [EXU_NREQ-1:0]        rsp_valid,
  input  logic [EXU_NREQ-1:0]        rsp_ready,
  output logic [EXU_NREQ*XLEN-1:0]   rsp_result,
  output logic                       share_alu_req,
  output logic                       share_bjp_req,
  output logic                       share_csr_req,
  input  logic [XLEN-1:0]            share_alu_res,
  input  logic [XLEN-1:0]            share_bjp_res,
  input  logic [XLEN-1:0]            share_csr_res
);

  logic [EXU_NREQ-1:0] vld_q, vld_d;
  logic [XLEN-1:0]     data_q [EXU_NREQ];
  logic [XLEN-1:0]     data_d [EXU_NREQ];
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [EXU_NREQ-1:0] elig;
  logic [EXU_NREQ-1:0] gnt;
  logic [XLEN-1:0]     res [EXU_NREQ];

  assign elig = req_valid & (~vld_q | rsp_ready) & {EXU_NREQ{~flush}};

  lieat_rr_arb3 u_pick (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign req_ready     = gnt;
  assign share_alu_req = gnt[EXU_REQ_ALU];
  assign share_bjp_req = gnt[EXU_REQ_BJP];
  assign share_csr_req = gnt[EXU_REQ_CSR];
  assign rsp_valid     = vld_q;

  assign res[EXU_REQ_ALU] = share_alu_res;
  assign res[EXU_REQ_BJP] = share_bjp_res;
  assign res[EXU_REQ_CSR] = share_csr_res;

  always_comb begin
    vld_d    = vld_q;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < EXU_NREQ; i++) begin
      data_d[i] = data_q[i];
      if (flush) begin
        vld_d[i] = 1'b0;
      end else if (gnt[i]) begin
        vld_d[i]  = 1'b1;
        data_d[i] = res[i];
      end else if (vld_q[i] && rsp_ready[i]) begin
        vld_d[i] = 1'b0;
      end
    end
    if (|gnt) rr_ptr_d = rr_next(gnt);
  end

  always_comb begin
    rsp_result = '0;
    for (int i = 0; i < EXU_NREQ; i++)
      rsp_result[XLEN*i +: XLEN] = data_q[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q    <= '0;
      rr_ptr_q <= 2'd0;
      for (int i = 0; i < EXU_NREQ; i++)
        data_q[i] <= '0;
    end else begin
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < EXU_NREQ; i++)
        data_q[i] <= data_d[i];
    end
  end

endmodule
